// File: rtl/coreriscv_axi4_client_tile_link_network_port_pkg.sv
// Shared types and constants for the client-side TileLink network port.
package coreriscv_axi4_client_tile_link_network_port_pkg;

  localparam int HDR_W        = 2;
  localparam int BEAT_W       = 3;
  localparam int ADDR_BLOCK_W = 26;
  localparam int DATA_W       = 64;
  localparam int XID_W        = 1;
  localparam int MXID_W       = 2;
  localparam int A_TYPE_W     = 3;
  localparam int R_TYPE_W     = 3;
  localparam int UNION_W      = 12;
  localparam int G_TYPE_W     = 4;
  localparam int P_TYPE_W     = 2;

  localparam logic IS_BUILTIN = 1'b1;

  typedef enum logic [G_TYPE_W-1:0] {
    G_DATA_SHARED = 4'h0,
    G_DATA_EXCL   = 4'h1,
    G_ACK         = 4'h2
  } g_type_e;

  typedef struct packed {
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [XID_W-1:0]        client_xact_id;
    logic [BEAT_W-1:0]       addr_beat;
    logic                    is_builtin_type;
    logic [A_TYPE_W-1:0]     a_type;
    logic [UNION_W-1:0]      union_bits;
    logic [DATA_W-1:0]       data;
  } acquire_t;

  typedef struct packed {
    logic [BEAT_W-1:0]       addr_beat;
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [XID_W-1:0]        client_xact_id;
    logic                    voluntary;
    logic [R_TYPE_W-1:0]     r_type;
    logic [DATA_W-1:0]       data;
  } release_t;

  typedef struct packed {
    logic [MXID_W-1:0] manager_xact_id;
    logic [HDR_W-1:0]  src;
  } finish_entry_t;

  // Custom ack grants always need a finish; data grants only on their final beat.
  function automatic logic grant_needs_finish(input logic                is_builtin_type,
                                              input logic [G_TYPE_W-1:0] g_type,
                                              input logic [BEAT_W-1:0]   addr_beat,
                                              input logic [BEAT_W-1:0]   last_beat);
    return (is_builtin_type != IS_BUILTIN) &&
           ((g_type == G_ACK) || (addr_beat == last_beat));
  endfunction

endpackage

// File: rtl/coreriscv_axi4_client_tile_link_network_port_if.sv
// Client-side and network-side TileLink channel bundle; slave = port, master = environment.
interface coreriscv_axi4_client_tile_link_network_port_if;
  import coreriscv_axi4_client_tile_link_network_port_pkg::*;

  logic                    io_client_acquire_ready;
  logic                    io_client_acquire_valid;
  logic [ADDR_BLOCK_W-1:0] io_client_acquire_bits_addr_block;
  logic [XID_W-1:0]        io_client_acquire_bits_client_xact_id;
  logic [BEAT_W-1:0]       io_client_acquire_bits_addr_beat;
  logic                    io_client_acquire_bits_is_builtin_type;
  logic [A_TYPE_W-1:0]     io_client_acquire_bits_a_type;
  logic [UNION_W-1:0]      io_client_acquire_bits_union;
  logic [DATA_W-1:0]       io_client_acquire_bits_data;

  logic                    io_client_release_ready;
  logic                    io_client_release_valid;
  logic [BEAT_W-1:0]       io_client_release_bits_addr_beat;
  logic [ADDR_BLOCK_W-1:0] io_client_release_bits_addr_block;
  logic [XID_W-1:0]        io_client_release_bits_client_xact_id;
  logic                    io_client_release_bits_voluntary;
  logic [R_TYPE_W-1:0]     io_client_release_bits_r_type;
  logic [DATA_W-1:0]       io_client_release_bits_data;

  logic                    io_client_grant_ready;
  logic                    io_client_grant_valid;
  logic [BEAT_W-1:0]       io_client_grant_bits_addr_beat;
  logic [XID_W-1:0]        io_client_grant_bits_client_xact_id;
  logic [MXID_W-1:0]       io_client_grant_bits_manager_xact_id;
  logic                    io_client_grant_bits_is_builtin_type;
  logic [G_TYPE_W-1:0]     io_client_grant_bits_g_type;
  logic [DATA_W-1:0]       io_client_grant_bits_data;

  logic                    io_client_probe_ready;
  logic                    io_client_probe_valid;
  logic [ADDR_BLOCK_W-1:0] io_client_probe_bits_addr_block;
  logic [P_TYPE_W-1:0]     io_client_probe_bits_p_type;

  logic                    io_network_acquire_ready;
  logic                    io_network_acquire_valid;
  logic [HDR_W-1:0]        io_network_acquire_bits_header_src;
  logic [HDR_W-1:0]        io_network_acquire_bits_header_dst;
  logic [ADDR_BLOCK_W-1:0] io_network_acquire_bits_payload_addr_block;
  logic [XID_W-1:0]        io_network_acquire_bits_payload_client_xact_id;
  logic [BEAT_W-1:0]       io_network_acquire_bits_payload_addr_beat;
  logic                    io_network_acquire_bits_payload_is_builtin_type;
  logic [A_TYPE_W-1:0]     io_network_acquire_bits_payload_a_type;
  logic [UNION_W-1:0]      io_network_acquire_bits_payload_union;
  logic [DATA_W-1:0]       io_network_acquire_bits_payload_data;

  logic                    io_network_release_ready;
  logic                    io_network_release_valid;
  logic [HDR_W-1:0]        io_network_release_bits_header_src;
  logic [HDR_W-1:0]        io_network_release_bits_header_dst;
  logic [BEAT_W-1:0]       io_network_release_bits_payload_addr_beat;
  logic [ADDR_BLOCK_W-1:0] io_network_release_bits_payload_addr_block;
  logic [XID_W-1:0]        io_network_release_bits_payload_client_xact_id;
  logic                    io_network_release_bits_payload_voluntary;
  logic [R_TYPE_W-1:0]     io_network_release_bits_payload_r_type;
  logic [DATA_W-1:0]       io_network_release_bits_payload_data;

  logic                    io_network_grant_ready;
  logic                    io_network_grant_valid;
  logic [HDR_W-1:0]        io_network_grant_bits_header_src;
  logic [HDR_W-1:0]        io_network_grant_bits_header_dst;
  logic [BEAT_W-1:0]       io_network_grant_bits_payload_addr_beat;
  logic [XID_W-1:0]        io_network_grant_bits_payload_client_xact_id;
  logic [MXID_W-1:0]       io_network_grant_bits_payload_manager_xact_id;
  logic                    io_network_grant_bits_payload_is_builtin_type;
  logic [G_TYPE_W-1:0]     io_network_grant_bits_payload_g_type;
  logic [DATA_W-1:0]       io_network_grant_bits_payload_data;

  logic                    io_network_probe_ready;
  logic                    io_network_probe_valid;
  logic [HDR_W-1:0]        io_network_probe_bits_header_src;
  logic [HDR_W-1:0]        io_network_probe_bits_header_dst;
  logic [ADDR_BLOCK_W-1:0] io_network_probe_bits_payload_addr_block;
  logic [P_TYPE_W-1:0]     io_network_probe_bits_payload_p_type;

  logic                    io_network_finish_ready;
  logic                    io_network_finish_valid;
  logic [HDR_W-1:0]        io_network_finish_bits_header_src;
  logic [HDR_W-1:0]        io_network_finish_bits_header_dst;
  logic [MXID_W-1:0]       io_network_finish_bits_payload_manager_xact_id;

  modport slave (
    output io_client_acquire_ready,
    input  io_client_acquire_valid, io_client_acquire_bits_addr_block,
           io_client_acquire_bits_client_xact_id, io_client_acquire_bits_addr_beat,
           io_client_acquire_bits_is_builtin_type, io_client_acquire_bits_a_type,
           io_client_acquire_bits_union, io_client_acquire_bits_data,
    output io_client_release_ready,
    input  io_client_release_valid, io_client_release_bits_addr_beat,
           io_client_release_bits_addr_block, io_client_release_bits_client_xact_id,
           io_client_release_bits_voluntary, io_client_release_bits_r_type,
           io_client_release_bits_data,
    input  io_client_grant_ready,
    output io_client_grant_valid, io_client_grant_bits_addr_beat,
           io_client_grant_bits_client_xact_id, io_client_grant_bits_manager_xact_id,
           io_client_grant_bits_is_builtin_type, io_client_grant_bits_g_type,
           io_client_grant_bits_data,
    input  io_client_probe_ready,
    output io_client_probe_valid, io_client_probe_bits_addr_block, io_client_probe_bits_p_type,
    input  io_network_acquire_ready,
    output io_network_acquire_valid, io_network_acquire_bits_header_src,
           io_network_acquire_bits_header_dst, io_network_acquire_bits_payload_addr_block,
           io_network_acquire_bits_payload_client_xact_id, io_network_acquire_bits_payload_addr_beat,
           io_network_acquire_bits_payload_is_builtin_type, io_network_acquire_bits_payload_a_type,
           io_network_acquire_bits_payload_union, io_network_acquire_bits_payload_data,
    input  io_network_release_ready,
    output io_network_release_valid, io_network_release_bits_header_src,
           io_network_release_bits_header_dst, io_network_release_bits_payload_addr_beat,
           io_network_release_bits_payload_addr_block, io_network_release_bits_payload_client_xact_id,
           io_network_release_bits_payload_voluntary, io_network_release_bits_payload_r_type,
           io_network_release_bits_payload_data,
    output io_network_grant_ready,
    input  io_network_grant_valid, io_network_grant_bits_header_src,
           io_network_grant_bits_header_dst, io_network_grant_bits_payload_addr_beat,
           io_network_grant_bits_payload_client_xact_id, io_network_grant_bits_payload_manager_xact_id,
           io_network_grant_bits_payload_is_builtin_type, io_network_grant_bits_payload_g_type,
           io_network_grant_bits_payload_data,
    output io_network_probe_ready,
    input  io_network_probe_valid, io_network_probe_bits_header_src,
           io_network_probe_bits_header_dst, io_network_probe_bits_payload_addr_block,
           io_network_probe_bits_payload_p_type,
    input  io_network_finish_ready,
    output io_network_finish_valid, io_network_finish_bits_header_src,
           io_network_finish_bits_header_dst, io_network_finish_bits_payload_manager_xact_id
  );

  modport master (
    input  io_client_acquire_ready,
    output io_client_acquire_valid, io_client_acquire_bits_addr_block,
           io_client_acquire_bits_client_xact_id, io_client_acquire_bits_addr_beat,
           io_client_acquire_bits_is_builtin_type, io_client_acquire_bits_a_type,
           io_client_acquire_bits_union, io_client_acquire_bits_data,
    input  io_client_release_ready,
    output io_client_release_valid, io_client_release_bits_addr_beat,
           io_client_release_bits_addr_block, io_client_release_bits_client_xact_id,
           io_client_release_bits_voluntary, io_client_release_bits_r_type,
           io_client_release_bits_data,
    output io_client_grant_ready,
    input  io_client_grant_valid, io_client_grant_bits_addr_beat,
           io_client_grant_bits_client_xact_id, io_client_grant_bits_manager_xact_id,
           io_client_grant_bits_is_builtin_type, io_client_grant_bits_g_type,
           io_client_grant_bits_data,
    output io_client_probe_ready,
    input  io_client_probe_valid, io_client_probe_bits_addr_block, io_client_probe_bits_p_type,
    output io_network_acquire_ready,
    input  io_network_acquire_valid, io_network_acquire_bits_header_src,
           io_network_acquire_bits_header_dst, io_network_acquire_bits_payload_addr_block,
           io_network_acquire_bits_payload_client_xact_id, io_network_acquire_bits_payload_addr_beat,
           io_network_acquire_bits_payload_is_builtin_type, io_network_acquire_bits_payload_a_type,
           io_network_acquire_bits_payload_union, io_network_acquire_bits_payload_data,
    output io_network_release_ready,
    input  io_network_release_valid, io_network_release_bits_header_src,
           io_network_release_bits_header_dst, io_network_release_bits_payload_addr_beat,
           io_network_release_bits_payload_addr_block, io_network_release_bits_payload_client_xact_id,
           io_network_release_bits_payload_voluntary, io_network_release_bits_payload_r_type,
           io_network_release_bits_payload_data,
    input  io_network_grant_ready,
    output io_network_grant_valid, io_network_grant_bits_header_src,
           io_network_grant_bits_header_dst, io_network_grant_bits_payload_addr_beat,
           io_network_grant_bits_payload_client_xact_id, io_network_grant_bits_payload_manager_xact_id,
           io_network_grant_bits_payload_is_builtin_type, io_network_grant_bits_payload_g_type,
           io_network_grant_bits_payload_data,
    input  io_network_probe_ready,
    output io_network_probe_valid, io_network_probe_bits_header_src,
           io_network_probe_bits_header_dst, io_network_probe_bits_payload_addr_block,
           io_network_probe_bits_payload_p_type,
    output io_network_finish_ready,
    input  io_network_finish_valid, io_network_finish_bits_header_src,
           io_network_finish_bits_header_dst, io_network_finish_bits_payload_manager_xact_id
  );

endinterface

// File: rtl/coreriscv_axi4_client_tile_link_network_port_reg_slice.sv
// One-entry valid/ready register slice: one cycle latency, full throughput.
module coreriscv_axi4_tl_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Refill whenever the slot is empty or being drained this cycle.
  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slot occupancy and payload capture
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/coreriscv_axi4_client_tile_link_network_port.sv
// Client-side network port: headers acquire/release, strips grant/probe headers,
// and queues finish messages for grants that must be acknowledged.
module coreriscv_axi4_client_tile_link_network_port
  import coreriscv_axi4_client_tile_link_network_port_pkg::*;
#(
  parameter logic [HDR_W-1:0] CLIENT_ID    = 2'h0,
  parameter logic [HDR_W-1:0] MANAGER_ID   = 2'h1,
  parameter int               FINISH_DEPTH = 2,
  parameter int               DATA_BEATS   = 8
) (
  input logic clk,
  input logic reset,
  coreriscv_axi4_client_tile_link_network_port_if.slave bus
);

  localparam int PTR_W = (FINISH_DEPTH > 1) ? $clog2(FINISH_DEPTH) : 1;
  localparam int CNT_W = $clog2(FINISH_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FINISH_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FINISH_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  acquire_t acq_in_s, acq_out_s;
  release_t rel_in_s, rel_out_s;

  assign acq_in_s = '{addr_block:      bus.io_client_acquire_bits_addr_block,
                      client_xact_id:  bus.io_client_acquire_bits_client_xact_id,
                      addr_beat:       bus.io_client_acquire_bits_addr_beat,
                      is_builtin_type: bus.io_client_acquire_bits_is_builtin_type,
                      a_type:          bus.io_client_acquire_bits_a_type,
                      union_bits:      bus.io_client_acquire_bits_union,
                      data:            bus.io_client_acquire_bits_data};

  assign rel_in_s = '{addr_beat:      bus.io_client_release_bits_addr_beat,
                      addr_block:     bus.io_client_release_bits_addr_block,
                      client_xact_id: bus.io_client_release_bits_client_xact_id,
                      voluntary:      bus.io_client_release_bits_voluntary,
                      r_type:         bus.io_client_release_bits_r_type,
                      data:           bus.io_client_release_bits_data};

  coreriscv_axi4_tl_reg_slice #(.WIDTH($bits(acquire_t))) u_acquire_slice (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.io_client_acquire_valid),
    .in_ready  (bus.io_client_acquire_ready),
    .in_data   (acq_in_s),
    .out_valid (bus.io_network_acquire_valid),
    .out_ready (bus.io_network_acquire_ready),
    .out_data  (acq_out_s)
  );

  coreriscv_axi4_tl_reg_slice #(.WIDTH($bits(release_t))) u_release_slice (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.io_client_release_valid),
    .in_ready  (bus.io_client_release_ready),
    .in_data   (rel_in_s),
    .out_valid (bus.io_network_release_valid),
    .out_ready (bus.io_network_release_ready),
    .out_data  (rel_out_s)
  );

  assign bus.io_network_acquire_bits_header_src              = CLIENT_ID;
  assign bus.io_network_acquire_bits_header_dst              = MANAGER_ID;
  assign bus.io_network_acquire_bits_payload_addr_block      = acq_out_s.addr_block;
  assign bus.io_network_acquire_bits_payload_client_xact_id  = acq_out_s.client_xact_id;
  assign bus.io_network_acquire_bits_payload_addr_beat       = acq_out_s.addr_beat;
  assign bus.io_network_acquire_bits_payload_is_builtin_type = acq_out_s.is_builtin_type;
  assign bus.io_network_acquire_bits_payload_a_type          = acq_out_s.a_type;
  assign bus.io_network_acquire_bits_payload_union           = acq_out_s.union_bits;
  assign bus.io_network_acquire_bits_payload_data            = acq_out_s.data;

  assign bus.io_network_release_bits_header_src             = CLIENT_ID;
  assign bus.io_network_release_bits_header_dst             = MANAGER_ID;
  assign bus.io_network_release_bits_payload_addr_beat      = rel_out_s.addr_beat;
  assign bus.io_network_release_bits_payload_addr_block     = rel_out_s.addr_block;
  assign bus.io_network_release_bits_payload_client_xact_id = rel_out_s.client_xact_id;
  assign bus.io_network_release_bits_payload_voluntary      = rel_out_s.voluntary;
  assign bus.io_network_release_bits_payload_r_type         = rel_out_s.r_type;
  assign bus.io_network_release_bits_payload_data           = rel_out_s.data;

  assign bus.io_client_probe_valid           = bus.io_network_probe_valid;
  assign bus.io_network_probe_ready          = bus.io_client_probe_ready;
  assign bus.io_client_probe_bits_addr_block = bus.io_network_probe_bits_payload_addr_block;
  assign bus.io_client_probe_bits_p_type     = bus.io_network_probe_bits_payload_p_type;

  // Headers the client never sees are deliberately dropped.
  logic unused_s;
  assign unused_s = ^{bus.io_network_grant_bits_header_dst,
                      bus.io_network_probe_bits_header_src,
                      bus.io_network_probe_bits_header_dst};

  logic             need_fin_s, grant_stall_s, fifo_full_s, push_s, pop_s;
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  finish_entry_t    fifo_mem_r [FINISH_DEPTH];

  assign need_fin_s = grant_needs_finish(bus.io_network_grant_bits_payload_is_builtin_type,
                                         bus.io_network_grant_bits_payload_g_type,
                                         bus.io_network_grant_bits_payload_addr_beat,
                                         LAST_BEAT);
  // Full FIFO stalls the grant even if a pop is in flight: no finish_ready->grant_ready path.
  assign fifo_full_s   = (count_r == FULL_CNT);
  assign grant_stall_s = need_fin_s && fifo_full_s;

  assign bus.io_client_grant_valid                = bus.io_network_grant_valid && !grant_stall_s;
  assign bus.io_network_grant_ready               = bus.io_client_grant_ready && !grant_stall_s;
  assign bus.io_client_grant_bits_addr_beat       = bus.io_network_grant_bits_payload_addr_beat;
  assign bus.io_client_grant_bits_client_xact_id  = bus.io_network_grant_bits_payload_client_xact_id;
  assign bus.io_client_grant_bits_manager_xact_id = bus.io_network_grant_bits_payload_manager_xact_id;
  assign bus.io_client_grant_bits_is_builtin_type = bus.io_network_grant_bits_payload_is_builtin_type;
  assign bus.io_client_grant_bits_g_type          = bus.io_network_grant_bits_payload_g_type;
  assign bus.io_client_grant_bits_data            = bus.io_network_grant_bits_payload_data;

  assign push_s = bus.io_network_grant_valid && bus.io_network_grant_ready && need_fin_s;
  assign pop_s  = bus.io_network_finish_valid && bus.io_network_finish_ready;

  assign bus.io_network_finish_valid                      = (count_r != '0);
  assign bus.io_network_finish_bits_header_src            = CLIENT_ID;
  assign bus.io_network_finish_bits_header_dst            = fifo_mem_r[rd_ptr_r].src;
  assign bus.io_network_finish_bits_payload_manager_xact_id = fifo_mem_r[rd_ptr_r].manager_xact_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Finish FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FINISH_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= '{manager_xact_id: bus.io_network_grant_bits_payload_manager_xact_id,
                                  src:             bus.io_network_grant_bits_header_src};
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

endmodule
